// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared operation encoding for the alu_pipe add/subtract unit
//
// Purpose: defines the operation enum and its width, used by alu_pipe and its
//          testbench.
// Contents: OP_W  - width of the op field
//           op_e  - ADD (a+b), SUB (a-b), ACC (acc+a), LDA (acc<-a)
package alu_pkg;

   localparam int OP_W = 2;

   typedef enum logic [OP_W-1:0] {
      ADD = 2'd0,
      SUB = 2'd1,
      ACC = 2'd2,
      LDA = 2'd3
   } op_e;

endpackage

// File: rtl/alu_pipe_add_sub_core.sv
// rtl/alu_pipe_add_sub_core.sv - combinational WIDTH-bit adder/subtractor with flags
//
// Purpose: computes x+y or x-y in WIDTH+1 bits and reports unsigned carry/borrow
//          and signed two's-complement overflow.
// Ports:   x, y  in  WIDTH  first and second operand
//          sub   in  1      1 selects x-y, 0 selects x+y
//          sum   out WIDTH  low WIDTH bits of the result
//          carry out 1      carry-out for add, borrow (x < y unsigned) for sub
//          ovf   out 1      signed overflow
module add_sub_core #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             sub,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             ovf
);

   logic [WIDTH:0] w_full;

   // In WIDTH+1 bits the top bit of x-y is set exactly when x < y, so the
   // same bit serves as carry for add and borrow for subtract.
   assign w_full = sub ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
   assign sum    = w_full[WIDTH-1:0];
   assign carry  = w_full[WIDTH];

   // Overflow: operand signs equal (add) or differ (sub) and the result sign
   // no longer matches the first operand.
   assign ovf = ((x[WIDTH-1] ^ y[WIDTH-1]) == sub) && (w_full[WIDTH-1] != x[WIDTH-1]);

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage pipelined add/subtract unit with accumulator
//
// Purpose: S1 registers the operation, S2 computes and registers the result and
//          flags; valid/ready handshake on both sides with full-rate throughput.
// Config:  ALU_PIPE_SAT_EN - when defined, overflowing results (and ACC writes)
//          clamp to the signed max/min; otherwise results wrap modulo 2^WIDTH.
// Ports:   clk, rst            clock, async active-high reset
//          in_valid/in_ready   operation handshake (in_ready combinational)
//          op, a, b            operation and operands (b unused by ACC/LDA)
//          out_valid/out_ready result handshake
//          res, carry, ovf,    registered result and flags
//          zero
//          acc                 current accumulator
module alu_pipe
   import alu_pkg::*;
#(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  op_e              op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] res,
   output logic             carry,
   output logic             ovf,
   output logic             zero,
   output logic [WIDTH-1:0] acc
);

   logic             r_s1_valid;
   op_e              r_s1_op;
   logic [WIDTH-1:0] r_s1_a;
   logic [WIDTH-1:0] r_s1_b;

   logic             r_s2_valid;
   logic [WIDTH-1:0] r_res;
   logic             r_carry;
   logic             r_ovf;
   logic             r_zero;
   logic [WIDTH-1:0] r_acc;

   logic             w_s1_adv;
   logic             w_s2_adv;
   logic [WIDTH-1:0] w_x;
   logic [WIDTH-1:0] w_y;
   logic             w_sub;
   logic [WIDTH-1:0] w_sum;
   logic             w_cout;
   logic             w_ovf;
   logic [WIDTH-1:0] w_arith;
   logic [WIDTH-1:0] w_res_nxt;
   logic             w_carry_nxt;
   logic             w_ovf_nxt;

   assign w_s2_adv = !r_s2_valid || out_ready;
   assign w_s1_adv = !r_s1_valid || w_s2_adv;
   assign in_ready = w_s1_adv;

   // ACC routes the accumulator into the first operand slot; the value read is
   // the one written by the previous transfer, so ACC chains need no bypass.
   assign w_sub = (r_s1_op == SUB);
   assign w_x   = (r_s1_op == ACC) ? r_acc  : r_s1_a;
   assign w_y   = (r_s1_op == ACC) ? r_s1_a : r_s1_b;

   add_sub_core #(.WIDTH(WIDTH)) u_core (
      .x     (w_x),
      .y     (w_y),
      .sub   (w_sub),
      .sum   (w_sum),
      .carry (w_cout),
      .ovf   (w_ovf)
   );

`ifdef ALU_PIPE_SAT_EN
   localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
   // Overflow direction follows the first operand's sign.
   assign w_arith = w_ovf ? (w_x[WIDTH-1] ? SMIN : SMAX) : w_sum;
`else
   assign w_arith = w_sum;
`endif

   always_comb begin
      w_res_nxt   = w_arith;
      w_carry_nxt = w_cout;
      w_ovf_nxt   = w_ovf;
      if (r_s1_op == LDA) begin
         w_res_nxt   = r_s1_a;
         w_carry_nxt = 1'b0;
         w_ovf_nxt   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_op    <= ADD;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
         r_s2_valid <= 1'b0;
         r_res      <= '0;
         r_carry    <= 1'b0;
         r_ovf      <= 1'b0;
         r_zero     <= 1'b0;
         r_acc      <= ACC_INIT;
      end else begin
         if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
               r_s1_op <= op;
               r_s1_a  <= a;
               r_s1_b  <= b;
            end
         end
         if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
               r_res   <= w_res_nxt;
               r_carry <= w_carry_nxt;
               r_ovf   <= w_ovf_nxt;
               r_zero  <= (w_res_nxt == '0);
               if (r_s1_op == ACC || r_s1_op == LDA)
                  r_acc <= w_res_nxt;
            end
         end
      end
   end

   assign out_valid = r_s2_valid;
   assign res       = r_res;
   assign carry     = r_carry;
   assign ovf       = r_ovf;
   assign zero      = r_zero;
   assign acc       = r_acc;

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - self-checking scoreboard bench for alu_pipe
module tb_alu_pipe;
   import alu_pkg::*;

   localparam int          W    = 8;
   localparam logic [W-1:0] INIT = 8'h5A;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   op_e          op_i = ADD;
   logic [W-1:0] a_i = '0;
   logic [W-1:0] b_i = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] res;
   logic         carry;
   logic         ovf;
   logic         zero;
   logic [W-1:0] acc;

   alu_pipe #(.WIDTH(W), .ACC_INIT(INIT)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op_i),
      .a         (a_i),
      .b         (b_i),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .res       (res),
      .carry     (carry),
      .ovf       (ovf),
      .zero      (zero),
      .acc       (acc)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] r;
      logic         c;
      logic         v;
      logic         z;
   } exp_t;

   exp_t         sb[$];
   logic [W-1:0] m_acc = INIT;
   int           n_checks = 0;
   int           n_pass = 0;
   int           n_results = 0;
   int           n_acc = 0;

   // Reference model: signed/unsigned integer arithmetic, expected value queued
   // at the moment the operation is accepted.
   task automatic push_expect(input op_e o, input logic [W-1:0] av, input logic [W-1:0] bv);
      int ux, uy, sx, sy, sr;
      exp_t e;
      logic [W-1:0] r;
      if (o == LDA) begin
         r = av; e.c = 1'b0; e.v = 1'b0; m_acc = av;
      end else begin
         if (o == ACC) begin
            ux = int'(m_acc); sx = int'($signed(m_acc));
            uy = int'(av);    sy = int'($signed(av));
         end else begin
            ux = int'(av); sx = int'($signed(av));
            uy = int'(bv); sy = int'($signed(bv));
         end
         if (o == SUB) begin
            sr = sx - sy; e.c = (ux < uy); r = W'(ux - uy);
         end else begin
            sr = sx + sy; e.c = ((ux + uy) >= (1 << W)); r = W'(ux + uy);
         end
         e.v = (sr > ((1 << (W-1)) - 1)) || (sr < -(1 << (W-1)));
`ifdef ALU_PIPE_SAT_EN
         if (e.v) r = (sr > 0) ? 8'h7F : 8'h80;
`endif
         if (o == ACC) m_acc = r;
      end
      e.r = r;
      e.z = (r == '0);
      sb.push_back(e);
      n_acc++;
   endtask

   // Scoreboard: compare every consumed result against the queued expectation.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         exp_t got, e;
         got = {res, carry, ovf, zero};
         n_checks++;
         if (sb.size() == 0) begin
            $display("FAIL result_unexpected got res=%h c=%b v=%b z=%b with empty queue", res, carry, ovf, zero);
         end else begin
            e = sb.pop_front();
            if (got !== e)
               $display("FAIL result got res=%h c=%b v=%b z=%b want res=%h c=%b v=%b z=%b",
                        got.r, got.c, got.v, got.z, e.r, e.c, e.v, e.z);
            else
               n_pass++;
         end
         n_results++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input op_e o, input logic [W-1:0] av, input logic [W-1:0] bv);
      int t;
      t = 0;
      in_valid = 1'b1; op_i = o; a_i = av; b_i = bv;
      forever begin
         @(negedge clk);
         if (in_ready) begin
            push_expect(o, av, bv);
            break;
         end
         t++;
         if (t > 50) begin
            n_checks++;
            $display("FAIL send_timeout in_ready=%b want 1", in_ready);
            break;
         end
         tick();
      end
      tick();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 60) begin
         tick();
         t++;
      end
      n_checks++;
      if (sb.size() != 0)
         $display("FAIL drain_timeout pending=%0d want 0", sb.size());
      else
         n_pass++;
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_checks++;
      if ({out_valid, in_ready, res, carry, ovf, zero, acc} !== {1'b0, 1'b1, 8'h00, 3'b000, INIT})
         $display("FAIL reset_state ov=%b ir=%b res=%h c=%b v=%b z=%b acc=%h want 0 1 00 0 0 0 %h",
                  out_valid, in_ready, res, carry, ovf, zero, acc, INIT);
      else
         n_pass++;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_add();
      logic [W-1:0] want;
`ifdef ALU_PIPE_SAT_EN
      want = 8'h7F;
`else
      want = 8'h80;
`endif
      out_ready = 1'b1;
      send(ADD, 8'h7F, 8'h01);
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL latency_early out_valid=%b want 0", out_valid);
      else n_pass++;
      tick();
      n_checks++;
      if ({out_valid, res, ovf} !== {1'b1, want, 1'b1})
         $display("FAIL add_ovf ov=%b res=%h ovf=%b want 1 %h 1", out_valid, res, ovf, want);
      else n_pass++;
      send(ADD, 8'hFF, 8'h01);
      send(ADD, 8'h12, 8'h34);
      drain();
   endtask

   task automatic test_sub();
      out_ready = 1'b1;
      send(SUB, 8'h03, 8'h05);
      send(SUB, 8'h05, 8'h05);
      send(SUB, 8'h80, 8'h01);
      drain();
   endtask

   task automatic test_acc_chain();
      out_ready = 1'b1;
      send(LDA, 8'h10, 8'hEE);
      repeat (3) send(ACC, 8'h05, 8'hEE);
      drain();
      n_checks++;
      if (acc !== 8'h1F) $display("FAIL acc_chain acc=%h want 1f", acc);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      int base_r, base_a;
      logic [W-1:0] held;
      base_r = n_results;
      base_a = n_acc;
      out_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 6; i++) send(ADD, 8'(8'h11 * i), 8'(i + 1));
         end
         begin
            repeat (2) tick();
            @(negedge clk);
            n_checks++;
            if (in_ready !== 1'b0 || (n_acc - base_a) != 2)
               $display("FAIL full_stall in_ready=%b accepts=%0d want 0 2", in_ready, n_acc - base_a);
            else n_pass++;
            held = res;
            repeat (2) tick();
            n_checks++;
            if (res !== held || out_valid !== 1'b1)
               $display("FAIL hold_stable res=%h ov=%b want %h 1", res, out_valid, held);
            else n_pass++;
            out_ready = 1'b1;
         end
      join
      drain();
      n_checks++;
      if ((n_results - base_r) != 6)
         $display("FAIL bp_count results=%0d want 6", n_results - base_r);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int base_r;
      logic ok;
      base_r = n_results;
      ok = 1'b1;
      out_ready = 1'b1;
      fork
         begin
            for (int i = 0; i < 8; i++) send(i[0] ? SUB : ADD, 8'(8'h23 * i), 8'(8'h07 + i));
         end
         begin
            repeat (8) begin
               @(negedge clk);
               if (in_ready !== 1'b1) ok = 1'b0;
            end
         end
      join
      repeat (3) tick();
      n_checks++;
      if (!ok || (n_results - base_r) != 8)
         $display("FAIL throughput ready_ok=%b results=%0d want 1 8", ok, n_results - base_r);
      else n_pass++;
      drain();
   endtask

   task automatic test_reset_mid();
      logic ok;
      n_checks++;
      if (acc !== 8'h1F) $display("FAIL pre_reset_acc acc=%h want 1f", acc);
      else n_pass++;
      out_ready = 1'b0;
      send(ADD, 8'h01, 8'h02);
      send(ADD, 8'h03, 8'h04);
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1)
         $display("FAIL pre_reset_full in_ready=%b ov=%b want 0 1", in_ready, out_valid);
      else n_pass++;
      tick();
      rst = 1'b1;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || acc !== INIT)
         $display("FAIL reset_mid ov=%b acc=%h want 0 %h", out_valid, acc, INIT);
      else n_pass++;
      sb.delete();
      m_acc = INIT;
      tick();
      rst = 1'b0;
      out_ready = 1'b1;
      ok = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (out_valid !== 1'b0) ok = 1'b0;
      end
      n_checks++;
      if (!ok) $display("FAIL reset_ghost out_valid pulse after reset, want none");
      else n_pass++;
      tick();
      send(ACC, 8'h01, 8'h00);
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || res !== 8'h5B)
         $display("FAIL post_reset ov=%b res=%h want 1 5b", out_valid, res);
      else n_pass++;
      drain();
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_acc_chain();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

endmodule
